// File: rtl/return_addr_stack_pkg.sv
// Shared definitions for the return address stack: overflow policies,
// per-cycle operation decode and sizing helpers.
package return_addr_stack_pkg;

  localparam int RAS_OVF_WRAP = 0;
  localparam int RAS_OVF_DROP = 1;

  typedef enum logic [2:0] {
    RAS_OP_IDLE,
    RAS_OP_FLUSH,
    RAS_OP_XCHG,
    RAS_OP_PUSH,
    RAS_OP_POP
  } ras_op_e;

  function automatic int ras_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ras_ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  // Priority: flush > push&pop > push > pop > idle.
  function automatic ras_op_e ras_decode(input logic do_flush,
                                         input logic do_push,
                                         input logic do_pop);
    if (do_flush)
      return RAS_OP_FLUSH;
    else if (do_push && do_pop)
      return RAS_OP_XCHG;
    else if (do_push)
      return RAS_OP_PUSH;
    else if (do_pop)
      return RAS_OP_POP;
    else
      return RAS_OP_IDLE;
  endfunction

endpackage

// File: rtl/return_addr_stack.sv
// Circular return address stack for CALL/RET prediction. The top pointer
// addresses the newest entry; a full push either overwrites the oldest or is dropped.
module return_addr_stack
  import return_addr_stack_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 8,
  parameter int OVF_MODE = RAS_OVF_WRAP
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [WIDTH-1:0]              push_data,
  input  logic                          pop,
  input  logic                          flush,
  output logic [WIDTH-1:0]              top_data,
  output logic                          empty,
  output logic                          full,
  output logic [ras_cnt_w(DEPTH)-1:0]   count,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int CNT_W = ras_cnt_w(DEPTH);
  localparam int PTR_W = ras_ptr_w(DEPTH);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  if (DEPTH < 2 || DEPTH > 64) begin : g_bad_depth
    $error("return_addr_stack: DEPTH must be in 2..64");
  end
  if (OVF_MODE != RAS_OVF_WRAP && OVF_MODE != RAS_OVF_DROP) begin : g_bad_mode
    $error("return_addr_stack: OVF_MODE must be 0 (wrap) or 1 (drop)");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] tp;

  logic [PTR_W-1:0] tp_d;
  logic [CNT_W-1:0] count_d;
  logic             wr_en;
  logic [PTR_W-1:0] wr_ptr;
  logic             ovf_d;
  logic             unf_d;
  logic             is_empty;
  logic             is_full;
  ras_op_e          op;

  // DEPTH need not be a power of two, so wrap is an explicit compare.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
    return (p == '0) ? PTR_LAST : p - PTR_W'(1);
  endfunction

  assign is_empty = (count == '0);
  assign is_full  = (count == CNT_FULL);

  always_comb begin
    op      = ras_decode(flush, push, pop);
    tp_d    = tp;
    count_d = count;
    wr_en   = 1'b0;
    wr_ptr  = tp;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    case (op)
      RAS_OP_FLUSH: begin
        tp_d    = '0;
        count_d = '0;
      end
      RAS_OP_XCHG: begin
        wr_en = 1'b1;
        if (is_empty) begin
          // Nothing to replace: acts as a plain push, but the pop was illegal.
          tp_d    = ptr_inc(tp);
          wr_ptr  = ptr_inc(tp);
          count_d = CNT_W'(1);
          unf_d   = 1'b1;
        end
      end
      RAS_OP_PUSH: begin
        if (!is_full) begin
          tp_d    = ptr_inc(tp);
          wr_en   = 1'b1;
          wr_ptr  = ptr_inc(tp);
          count_d = count + CNT_W'(1);
        end else begin
          ovf_d = 1'b1;
          // When full, tp+1 is the oldest slot, so advancing overwrites it.
          if (OVF_MODE == RAS_OVF_WRAP) begin
            tp_d   = ptr_inc(tp);
            wr_en  = 1'b1;
            wr_ptr = ptr_inc(tp);
          end
        end
      end
      RAS_OP_POP: begin
        if (!is_empty) begin
          tp_d    = ptr_dec(tp);
          count_d = count - CNT_W'(1);
        end else begin
          unf_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Storage is intentionally left out of reset; it is invisible while count is 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tp        <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      tp        <= tp_d;
      count     <= count_d;
      overflow  <= ovf_d;
      underflow <= unf_d;
      if (wr_en)
        mem[wr_ptr] <= push_data;
    end
  end

  assign empty    = is_empty;
  assign full     = is_full;
  assign top_data = is_empty ? '0 : mem[tp];

endmodule

// File: tb/tb_return_addr_stack.sv
// Directed bench: a wrap-mode and a drop-mode stack (DEPTH=4) share stimulus
// and are compared against hand-computed values.
module tb_return_addr_stack;

  logic        clk = 1'b0;
  logic        rst;
  logic        push, pop, flush;
  logic [15:0] push_data;

  logic [15:0] top_w, top_d;
  logic        empty_w, empty_d, full_w, full_d;
  logic [2:0]  count_w, count_d;
  logic        ovf_w, ovf_d, unf_w, unf_d;

  int checks = 0;
  int errors = 0;

  return_addr_stack #(.WIDTH(16), .DEPTH(4), .OVF_MODE(0)) u_wrap (
    .clk(clk), .rst(rst), .push(push), .push_data(push_data), .pop(pop),
    .flush(flush), .top_data(top_w), .empty(empty_w), .full(full_w),
    .count(count_w), .overflow(ovf_w), .underflow(unf_w)
  );

  return_addr_stack #(.WIDTH(16), .DEPTH(4), .OVF_MODE(1)) u_drop (
    .clk(clk), .rst(rst), .push(push), .push_data(push_data), .pop(pop),
    .flush(flush), .top_data(top_d), .empty(empty_d), .full(full_d),
    .count(count_d), .overflow(ovf_d), .underflow(unf_d)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle with the given inputs; returns 1ns after the rising edge.
  task automatic cyc(input logic pu, input logic po, input logic fl, input logic [15:0] d);
    push = pu; pop = po; flush = fl; push_data = d;
    @(posedge clk); #1;
    push = 1'b0; pop = 1'b0; flush = 1'b0; push_data = '0;
  endtask

  initial begin
    logic [15:0] exp_w [4];
    logic [15:0] exp_d [4];
    logic [15:0] lifo  [3];
    exp_w = '{16'h0005, 16'h0004, 16'h0003, 16'h0002};
    exp_d = '{16'h0004, 16'h0003, 16'h0002, 16'h0001};
    lifo  = '{16'h0033, 16'h0022, 16'h0011};

    rst = 1'b0; push = 1'b0; pop = 1'b0; flush = 1'b0; push_data = '0;
    #12;
    check("rst_empty", empty_w, 1);
    check("rst_count", count_w, 0);
    check("rst_top",   top_w,   0);
    check("rst_full",  full_w,  0);
    check("rst_flags", {ovf_w, unf_w, ovf_d, unf_d}, 0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    // LIFO order
    cyc(1, 0, 0, 16'h0011);
    cyc(1, 0, 0, 16'h0022);
    cyc(1, 0, 0, 16'h0033);
    check("lifo_count", count_w, 3);
    for (int i = 0; i < 3; i++) begin
      pop = 1'b1;
      check("lifo_pop_top", top_w, lifo[i]);
      @(posedge clk); #1;
      pop = 1'b0;
    end
    check("lifo_empty", empty_w, 1);
    check("lifo_count0", count_w, 0);
    check("lifo_top0", top_w, 0);

    // Overflow: wrap vs drop
    for (int i = 1; i <= 4; i++) cyc(1, 0, 0, 16'(i));
    check("fill_full_w", full_w, 1);
    check("fill_full_d", full_d, 1);
    check("fill_no_ovf", {ovf_w, ovf_d}, 0);
    cyc(1, 0, 0, 16'h0005);
    check("ovf_w", ovf_w, 1);
    check("ovf_d", ovf_d, 1);
    check("ovf_count_w", count_w, 4);
    check("ovf_count_d", count_d, 4);
    check("ovf_top_w", top_w, 16'h0005);
    check("ovf_top_d", top_d, 16'h0004);
    cyc(0, 0, 0, 16'h0000);
    check("ovf_pulse_end", {ovf_w, ovf_d}, 0);
    for (int i = 0; i < 4; i++) begin
      pop = 1'b1;
      check("wrap_pop_top", top_w, exp_w[i]);
      check("drop_pop_top", top_d, exp_d[i]);
      @(posedge clk); #1;
      pop = 1'b0;
    end
    check("ovf_drain_empty", {empty_w, empty_d}, 2'b11);

    // Underflow and push&pop
    cyc(0, 1, 0, 16'h0000);
    check("unf_pop", unf_w, 1);
    check("unf_count", count_w, 0);
    cyc(0, 1, 0, 16'h0000);
    check("unf_b2b", unf_w, 1);
    cyc(0, 0, 0, 16'h0000);
    check("unf_pulse_end", unf_w, 0);
    cyc(1, 1, 0, 16'h00AA);
    check("xchg_e_count", count_w, 1);
    check("xchg_e_top", top_w, 16'h00AA);
    check("xchg_e_unf", unf_w, 1);
    cyc(1, 1, 0, 16'h00BB);
    check("xchg_count", count_w, 1);
    check("xchg_top", top_w, 16'h00BB);
    check("xchg_flags", {unf_w, ovf_w}, 0);
    cyc(0, 1, 0, 16'h0000);
    check("xchg_drain", count_w, 0);

    // Flush beats push
    cyc(1, 0, 0, 16'h0041);
    cyc(1, 0, 0, 16'h0042);
    cyc(1, 0, 0, 16'h0043);
    check("flush_pre_count", count_w, 3);
    cyc(1, 0, 1, 16'h0077);
    check("flush_count", count_w, 0);
    check("flush_empty", empty_w, 1);
    check("flush_flags", {ovf_w, unf_w}, 0);
    check("flush_top", top_w, 0);
    cyc(1, 0, 0, 16'h0078);
    check("post_flush_count", count_w, 1);
    check("post_flush_top", top_w, 16'h0078);

    // Asynchronous reset between edges
    cyc(1, 0, 0, 16'h0079);
    check("pre_rst_count", count_w, 2);
    #2 rst = 1'b0;
    #1;
    check("arst_count", count_w, 0);
    check("arst_empty", empty_w, 1);
    check("arst_top", top_w, 0);
    check("arst_full", full_w, 0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    cyc(1, 0, 0, 16'h0099);
    check("post_rst_count", count_w, 1);
    check("post_rst_top", top_w, 16'h0099);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/return_addr_stack.md
RETURN_ADDR_STACK -- requirements
Module: return_addr_stack

Interface
REQ-001 Parameter WIDTH, default 16, address/data width of each entry.
REQ-002 Parameter DEPTH, default 8, number of entries; legal range 2..64, not required to be a power of two.
REQ-003 Parameter OVF_MODE, default 0, full-push policy: 0 = wrap (overwrite oldest), 1 = drop (discard push).
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 push  input  1  CALL: store push_data as new top.
REQ-007 push_data  input  WIDTH  return address to store (PC+1 of the CALL).
REQ-008 pop  input  1  RET: remove current top.
REQ-009 flush  input  1  discard all entries.
REQ-010 top_data  output  WIDTH  current top entry, combinational from state; 0 when empty.
REQ-011 empty  output  1  count == 0.
REQ-012 full  output  1  count == DEPTH.
REQ-013 count  output  clog2(DEPTH+1)  number of valid entries.
REQ-014 overflow  output  1  registered one-cycle pulse, push lost or oldest entry overwritten.
REQ-015 underflow  output  1  registered one-cycle pulse, pop attempted while empty.

Function
REQ-016 Storage SHALL be a circular array of DEPTH entries with top pointer tp (0..DEPTH-1) and counter count; pointer arithmetic SHALL wrap modulo DEPTH explicitly.
REQ-017 Priority per cycle SHALL be: flush > push&pop > push > pop > idle.
REQ-018 flush SHALL set count=0 and tp=0 next cycle, ignore push/pop that cycle, and leave overflow/underflow low.
REQ-019 push only, not full: tp<=tp+1 mod DEPTH, entry[tp+1]<=push_data, count<=count+1.
REQ-020 push only, full, OVF_MODE=0: same pointer advance and write (oldest entry overwritten), count stays DEPTH, overflow pulses next cycle.
REQ-021 push only, full, OVF_MODE=1: no state change, overflow pulses next cycle.
REQ-022 pop only, not empty: tp<=tp-1 mod DEPTH, count<=count-1; popped value is top_data in the pop cycle.
REQ-023 pop only, empty: no state change, underflow pulses next cycle.
REQ-024 push&pop, not empty: entry[tp]<=push_data, tp and count unchanged, no flag.
REQ-025 push&pop, empty: behaves as push only (count becomes 1, top = push_data) and underflow pulses next cycle.
REQ-026 top_data SHALL reflect a write on the cycle after the edge that performs it (no same-cycle bypass of push_data).
REQ-027 overflow and underflow SHALL be high for exactly one cycle per offending event; back-to-back events give back-to-back pulses.
REQ-028 No combinational path from push/pop/flush/push_data to any output.

Reset
REQ-029 Asserting rst (low) SHALL immediately force count=0, tp=0, empty=1, full=0, top_data=0, overflow=0, underflow=0, regardless of clk.
REQ-030 Storage entries SHALL NOT be reset; their contents are unobservable while count==0.
REQ-031 Reset mid-operation SHALL discard all entries; the first push after deassertion SHALL yield count=1.

Structure
REQ-032 Shared package SHALL hold the OVF_MODE constants (RAS_OVF_WRAP=0, RAS_OVF_DROP=1) and the count-width function.
REQ-033 No sub-module; storage, pointer and counter logic stay in one module with a single sequential process and a single next-state combinational process.
REQ-034 Elaboration SHALL reject DEPTH<2 or OVF_MODE outside {0,1}.

Verification (WIDTH=16, DEPTH=4 unless noted)
REQ-035 Push 0x0011,0x0022,0x0033 then pop x3 -> top_data 0x0033,0x0022,0x0011 in the pop cycles, then empty=1, count=0, top_data=0.
REQ-036 OVF_MODE=0: push 0x0001..0x0005 -> overflow pulse after 5th push, count=4; pops return 0x0005,0x0004,0x0003,0x0002.
REQ-037 OVF_MODE=1: push 0x0001..0x0005 -> overflow pulse after 5th push, count=4; pops return 0x0004,0x0003,0x0002,0x0001.
REQ-038 Empty stack: pop -> underflow pulse, count 0. Then push&pop 0x00AA -> count=1, top 0x00AA, underflow pulse. Then push&pop 0x00BB -> count=1, top 0x00BB, no pulse.
REQ-039 count=3, assert flush together with push 0x0077 -> count=0, empty=1, no flags; the next push 0x0078 gives count=1, top 0x0078.
REQ-040 count=2, pull rst low between edges -> outputs reach reset values before next edge; release, push 0x0099 -> count=1, top 0x0099.
